// File: rtl/icache_responder_pkg.sv
// icache_responder_pkg
//   Shared types and constants for the instruction-side cache responder:
//   word type, default geometry, address split, frame layout and FSM states.
//   Optional feature macro used by the top: ICACHE_STATS_EN.
package icache_responder_pkg;

   typedef logic [31:0] word_t;

   localparam int ICACHE_SETS = 16;
   localparam int IIDX_W      = $clog2(ICACHE_SETS);
   localparam int ITAG_W      = 32 - IIDX_W - 2;
   // Frames hold the widest tag any legal SETS (>= 2) can produce, zero-extended.
   localparam int ITAG_MAX_W  = 29;

   typedef struct packed {
      logic [ITAG_W-1:0] tag;
      logic [IIDX_W-1:0] idx;
      logic [1:0]        bytoff;
   } icache_addr_t;

   typedef struct packed {
      logic                  valid;
      logic [ITAG_MAX_W-1:0] tag;
      word_t                 data;
   } icache_frame_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache_responder_if.sv
// icache_responder_if
//   Bundles the fetch-side (imem*) and memory-side (i*) signals of the
//   instruction cache.
//   slave  : the cache's view (takes requests, returns instructions, reads memory)
//   master : the environment's view (fetch stage + memory arbiter)
interface icache_responder_if;
   import icache_responder_pkg::*;

   logic  imemREN;
   word_t imemaddr;
   logic  inval;
   logic  ihit;
   word_t imemload;
   logic  iREN;
   word_t iaddr;
   logic  iwait;
   word_t iload;

   modport slave (
      input  imemREN, imemaddr, inval, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, inval, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache_responder_frames.sv
// icache_frames
//   Direct-mapped frame storage: one combinational read port, one write
//   port, bulk invalidate. Invalidate overrides the valid bit of a write
//   landing on the same edge.
//   CLK, nRST          : clock, async active-low reset
//   rd_idx_i/rd_frame_o: combinational lookup
//   wr_en_i/wr_idx_i/wr_frame_i : frame fill
//   inval_i            : clear every valid bit at the next edge
module icache_frames
   import icache_responder_pkg::*;
#(
   parameter int    SETS             = ICACHE_SETS,
   parameter word_t RESET_FRAME_DATA = 32'h0,
   localparam int   IDX_W            = $clog2(SETS)
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [IDX_W-1:0]   rd_idx_i,
   output icache_frame_t      rd_frame_o,
   input  logic               wr_en_i,
   input  logic [IDX_W-1:0]   wr_idx_i,
   input  icache_frame_t      wr_frame_i,
   input  logic               inval_i
);

   icache_frame_t frames_q [SETS];

   assign rd_frame_o = frames_q[rd_idx_i];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < SETS; i++) begin
            frames_q[i].valid <= 1'b0;
            frames_q[i].tag   <= '0;
            frames_q[i].data  <= RESET_FRAME_DATA;
         end
      end else begin
         if (wr_en_i)
            frames_q[wr_idx_i] <= wr_frame_i;
         if (inval_i)
            for (int i = 0; i < SETS; i++)
               frames_q[i].valid <= 1'b0;
      end
   end

endmodule

// File: rtl/icache_responder.sv
// icache_responder
//   Direct-mapped, one-word-per-block instruction cache between the fetch
//   stage and the memory arbiter. Hits answer combinationally; a miss
//   issues one word read and fills the frame.
//   CLK, nRST : clock, async active-low reset
//   bus       : icache_responder_if.slave (imem* fetch side, i* memory side)
//   hit_count, miss_count : saturating statistics, only with ICACHE_STATS_EN
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | look up imemaddr; hit answers now, miss latches miss_addr
//   FETCH | read miss_addr from memory until iwait drops, then fill
module icache_responder
   import icache_responder_pkg::*;
#(
   parameter int    SETS             = ICACHE_SETS,
   parameter word_t RESET_FRAME_DATA = 32'h0
) (
   input  logic              CLK,
   input  logic              nRST,
   icache_responder_if.slave bus
`ifdef ICACHE_STATS_EN
   ,
   output word_t             hit_count,
   output word_t             miss_count
`endif
);

   localparam int IDX_W = $clog2(SETS);

   icache_state_t         state_q, state_d;
   word_t                 miss_addr_q, miss_addr_d;
   logic                  inval_pend_q, inval_pend_d;
   logic [IDX_W-1:0]      rd_idx, wr_idx;
   logic [ITAG_MAX_W-1:0] rd_tag;
   icache_frame_t         rd_frame, wr_frame;
   logic                  wr_en;
   logic                  hit;

   assign rd_idx = IDX_W'(bus.imemaddr >> 2);
   assign rd_tag = ITAG_MAX_W'(bus.imemaddr >> (IDX_W + 2));
   assign wr_idx = IDX_W'(miss_addr_q >> 2);

   assign hit = (state_q == IDLE) && bus.imemREN && !bus.inval &&
                rd_frame.valid && (rd_frame.tag == rd_tag);

   icache_frames #(
      .SETS             (SETS),
      .RESET_FRAME_DATA (RESET_FRAME_DATA)
   ) u_frames (
      .CLK        (CLK),
      .nRST       (nRST),
      .rd_idx_i   (rd_idx),
      .rd_frame_o (rd_frame),
      .wr_en_i    (wr_en),
      .wr_idx_i   (wr_idx),
      .wr_frame_i (wr_frame),
      .inval_i    (bus.inval)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         miss_addr_q  <= '0;
         inval_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         miss_addr_q  <= miss_addr_d;
         inval_pend_q <= inval_pend_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      miss_addr_d    = miss_addr_q;
      inval_pend_d   = inval_pend_q;
      bus.ihit       = 1'b0;
      bus.imemload   = '0;
      bus.iREN       = 1'b0;
      bus.iaddr      = '0;
      wr_en          = 1'b0;
      // Any inval seen during the read poisons the fill.
      wr_frame.valid = !(bus.inval || inval_pend_q);
      wr_frame.tag   = ITAG_MAX_W'(miss_addr_q >> (IDX_W + 2));
      wr_frame.data  = bus.iload;
      unique case (state_q)
         IDLE: begin
            if (hit) begin
               bus.ihit     = 1'b1;
               bus.imemload = rd_frame.data;
            end else if (bus.imemREN && !bus.inval) begin
               // An inval cycle only flushes; the request is re-looked-up next cycle.
               miss_addr_d  = bus.imemaddr;
               inval_pend_d = 1'b0;
               state_d      = FETCH;
            end
         end
         FETCH: begin
            bus.iREN  = 1'b1;
            bus.iaddr = miss_addr_q & 32'hFFFF_FFFC;
            if (bus.inval)
               inval_pend_d = 1'b1;
            if (!bus.iwait) begin
               wr_en        = 1'b1;
               inval_pend_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef ICACHE_STATS_EN
   word_t hit_count_q, miss_count_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         if (bus.ihit && hit_count_q != 32'hFFFF_FFFF)
            hit_count_q <= hit_count_q + 32'd1;
         if (state_q == IDLE && state_d == FETCH && miss_count_q != 32'hFFFF_FFFF)
            miss_count_q <= miss_count_q + 32'd1;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder
//   Directed bench for icache_responder: cold miss with memory wait states,
//   conflict eviction, address change during a fill, invalidation, reset
//   mid-fill and (with ICACHE_STATS_EN) the statistics counters.
module tb_icache_responder;
   import icache_responder_pkg::*;

   logic CLK;
   logic nRST;
   int   n_cmp;
   int   n_bad;

   icache_responder_if bus();

`ifdef ICACHE_STATS_EN
   word_t hit_count, miss_count;
`endif

   icache_responder dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .bus        (bus)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input word_t got, input word_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Starts in IDLE with a request that must miss; leaves the DUT back in IDLE.
   task automatic do_miss(input string tag, input word_t a, input int waits, input word_t d);
      bus.imemREN  = 1'b1;
      bus.imemaddr = a;
      bus.iwait    = 1'b1;
      #1;
      chk({tag, " detect ihit"}, {31'b0, bus.ihit}, 32'd0);
      chk({tag, " detect iREN"}, {31'b0, bus.iREN}, 32'd0);
      tick();
      for (int i = 0; i < waits; i++) begin
         chk({tag, " wait iREN"}, {31'b0, bus.iREN}, 32'd1);
         chk({tag, " wait iaddr"}, bus.iaddr, a);
         chk({tag, " wait ihit"}, {31'b0, bus.ihit}, 32'd0);
         tick();
      end
      bus.iwait = 1'b0;
      bus.iload = d;
      #1;
      chk({tag, " fill iREN"}, {31'b0, bus.iREN}, 32'd1);
      chk({tag, " fill iaddr"}, bus.iaddr, a);
      chk({tag, " fill ihit"}, {31'b0, bus.ihit}, 32'd0);
      tick();
      bus.iwait = 1'b1;
      bus.iload = 32'hDEAD_BEEF;
   endtask

   task automatic expect_hit(input string tag, input word_t a, input word_t d);
      bus.imemREN  = 1'b1;
      bus.imemaddr = a;
      #1;
      chk({tag, " ihit"}, {31'b0, bus.ihit}, 32'd1);
      chk({tag, " imemload"}, bus.imemload, d);
      chk({tag, " iREN"}, {31'b0, bus.iREN}, 32'd0);
      tick();
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      nRST         = 1'b0;
      bus.imemREN  = 1'b0;
      bus.imemaddr = '0;
      bus.inval    = 1'b0;
      bus.iwait    = 1'b1;
      bus.iload    = '0;

      // Reset state
      #2;
      chk("rst ihit", {31'b0, bus.ihit}, 32'd0);
      chk("rst imemload", bus.imemload, 32'd0);
      chk("rst iREN", {31'b0, bus.iREN}, 32'd0);
      chk("rst iaddr", bus.iaddr, 32'd0);
      tick();
      nRST = 1'b1;
      tick();

      // Cold miss with 3 wait cycles, then hit
      do_miss("cold40", 32'h40, 3, 32'h2008_0005);
      expect_hit("hit40", 32'h40, 32'h2008_0005);

      // Conflict: 0x440 shares index 0, then 0x40 is evicted
      do_miss("conf440", 32'h440, 0, 32'hAAAA_0440);
      expect_hit("hit440", 32'h440, 32'hAAAA_0440);
      do_miss("evict40", 32'h40, 1, 32'h2008_0005);
      expect_hit("rehit40", 32'h40, 32'h2008_0005);

      // Address moves to 0x84 during the 0x80 fill
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h80;
      bus.iwait    = 1'b1;
      tick();
      bus.imemaddr = 32'h84;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("mv iaddr held", bus.iaddr, 32'h80);
         chk("mv ihit", {31'b0, bus.ihit}, 32'd0);
         tick();
      end
      bus.iwait = 1'b0;
      bus.iload = 32'h1111_0080;
      #1;
      chk("mv fill iaddr", bus.iaddr, 32'h80);
      tick();
      bus.iwait = 1'b1;
      do_miss("miss84", 32'h84, 1, 32'h2222_0084);
      expect_hit("hit84", 32'h84, 32'h2222_0084);
      expect_hit("hit80", 32'h80, 32'h1111_0080);

      // imemREN low: no hit, no data
      bus.imemREN  = 1'b0;
      bus.imemaddr = 32'h84;
      #1;
      chk("noren ihit", {31'b0, bus.ihit}, 32'd0);
      chk("noren imemload", bus.imemload, 32'd0);
      chk("noren iREN", {31'b0, bus.iREN}, 32'd0);
      tick();

      // inval pulse kills the hit and the frame
      do_miss("miss10", 32'h10, 0, 32'h3333_0010);
      expect_hit("hit10", 32'h10, 32'h3333_0010);
      bus.imemaddr = 32'h10;
      bus.inval    = 1'b1;
      #1;
      chk("inval ihit", {31'b0, bus.ihit}, 32'd0);
      tick();
      bus.inval = 1'b0;
      do_miss("postinv10", 32'h10, 0, 32'h3333_0010);
      expect_hit("rehit10", 32'h10, 32'h3333_0010);

      // inval coincident with fill completion
      bus.imemaddr = 32'h20;
      bus.iwait    = 1'b1;
      tick();
      tick();
      bus.iwait = 1'b0;
      bus.iload = 32'h4444_0020;
      bus.inval = 1'b1;
      tick();
      bus.inval = 1'b0;
      bus.iwait = 1'b1;
      #1;
      chk("invfill ihit", {31'b0, bus.ihit}, 32'd0);
      do_miss("invfill20", 32'h20, 0, 32'h4444_0020);
      expect_hit("hit20", 32'h20, 32'h4444_0020);

      // Reset mid-FETCH
      do_miss("prime40", 32'h40, 0, 32'h2008_0005);
      expect_hit("prim40hit", 32'h40, 32'h2008_0005);
      bus.imemaddr = 32'h104;
      bus.iwait    = 1'b1;
      tick();
      chk("pre-rst iREN", {31'b0, bus.iREN}, 32'd1);
      nRST = 1'b0;
      #1;
      chk("midrst iREN", {31'b0, bus.iREN}, 32'd0);
      chk("midrst iaddr", bus.iaddr, 32'd0);
      chk("midrst ihit", {31'b0, bus.ihit}, 32'd0);
      tick();
      nRST = 1'b1;
      do_miss("postrst40", 32'h40, 0, 32'h2008_0005);
      expect_hit("postrsthit", 32'h40, 32'h2008_0005);

`ifdef ICACHE_STATS_EN
      nRST = 1'b0;
      #1;
      chk("stat rst hits", hit_count, 32'd0);
      chk("stat rst miss", miss_count, 32'd0);
      tick();
      nRST = 1'b1;
      do_miss("st0", 32'h0, 1, 32'h5555_0000);
      for (int i = 0; i < 3; i++)
         expect_hit("sthit0", 32'h0, 32'h5555_0000);
      do_miss("st4", 32'h4, 0, 32'h5555_0004);
      bus.imemREN = 1'b0;
      #1;
      chk("stat hits", hit_count, 32'd3);
      chk("stat miss", miss_count, 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
